// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// It generates the stall and flush controls for the pipeline registers and the
// EX-stage forwarding selects. A small FSM freezes the pipeline while data
// memory is busy and flags a sticky error if memory never answers.
// It also keeps saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_ex_rs1,
  input  logic [4:0]       i_ex_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_reg_write,
  input  logic [1:0]       i_ex_result_src,
  input  logic             i_ex_pc_src,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_reg_write,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_stall_mem,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_flush_wb,
  output logic [1:0]       o_forward_a,
  output logic [1:0]       o_forward_b,
  output logic             o_mem_error,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_memError;
  logic [CNT_W-1:0]  r_stallCycles;
  logic [CNT_W-1:0]  r_flushCount;
  logic              w_freeze;
  logic              w_loadUse;
  logic              w_branchFlush;

  // FSM state register; an asynchronous reset always lands back in RUN.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= RUN;
    else         r_state <= w_nextState;
  end

  // Next-state logic: enter MEM_WAIT on an unanswered access and give up after the timeout.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN: begin
        if (i_dmem_req && !i_dmem_ready) w_nextState = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (i_dmem_ready)                w_nextState = RUN;
        else if (r_waitCnt == LAST_WAIT) w_nextState = ERROR;
      end
      default: w_nextState = ERROR;
    endcase
  end

  // FSM output: freeze holds the whole pipeline while memory is outstanding or dead.
  always_comb begin
    w_freeze = 1'b0;
    case (r_state)
      RUN:      w_freeze = i_dmem_req & ~i_dmem_ready;
      MEM_WAIT: w_freeze = ~i_dmem_ready;
      default:  w_freeze = 1'b1;
    endcase
  end

  // Wait counter: cleared when an access starts stalling, incremented for each further unanswered cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_waitCnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_dmem_req && !i_dmem_ready) r_waitCnt <= '0;
        end
        MEM_WAIT: begin
          if (!i_dmem_ready && r_waitCnt != LAST_WAIT) r_waitCnt <= r_waitCnt + 1'b1;
        end
        default: r_waitCnt <= r_waitCnt;
      endcase
    end
  end

  // Sticky memory error, raised on the edge that enters ERROR.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                        r_memError <= 1'b0;
    else if (r_state == MEM_WAIT && w_nextState == ERROR) r_memError <= 1'b1;
  end

  assign w_loadUse = (i_ex_result_src == 2'b01) && i_ex_reg_write && (i_ex_rd != 5'd0) &&
                     ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
  assign w_branchFlush = ~i_reset & ~w_freeze & i_ex_pc_src;

  // Stall/flush generation: freeze dominates, then branch, then load-use.
  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_stall_ex  = 1'b0;
    o_stall_mem = 1'b0;
    o_flush_id  = 1'b0;
    o_flush_ex  = 1'b0;
    o_flush_wb  = 1'b0;
    if (!i_reset) begin
      if (w_freeze) begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_stall_ex  = 1'b1;
        o_stall_mem = 1'b1;
        o_flush_wb  = 1'b1;
      end else if (i_ex_pc_src) begin
        o_flush_id = 1'b1;
        o_flush_ex = 1'b1;
      end else if (w_loadUse) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_flush_ex = 1'b1;
      end
    end
  end

  // Forwarding selects: the younger MEM result wins over WB, and x0 is never forwarded.
  always_comb begin
    o_forward_a = 2'b00;
    o_forward_b = 2'b00;
    if (!i_reset) begin
      if (i_mem_reg_write && i_mem_rd != 5'd0 && i_mem_rd == i_ex_rs1)      o_forward_a = 2'b10;
      else if (i_wb_reg_write && i_wb_rd != 5'd0 && i_wb_rd == i_ex_rs1)    o_forward_a = 2'b01;
      if (i_mem_reg_write && i_mem_rd != 5'd0 && i_mem_rd == i_ex_rs2)      o_forward_b = 2'b10;
      else if (i_wb_reg_write && i_wb_rd != 5'd0 && i_wb_rd == i_ex_rs2)    o_forward_b = 2'b01;
    end
  end

  // Performance counters, both saturating at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (o_stall_if && r_stallCycles != '1)   r_stallCycles <= r_stallCycles + 1'b1;
      if (w_branchFlush && r_flushCount != '1) r_flushCount  <= r_flushCount + 1'b1;
    end
  end

  assign o_mem_error    = r_memError;
  assign o_stall_cycles = r_stallCycles;
  assign o_flush_count  = r_flushCount;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and it produces the EX-stage forwarding selects. It contains a small FSM that freezes the pipeline while the data memory is busy and latches a sticky error if the memory does not respond within a set time. It also keeps saturating performance counters for stalls and flushes.

Parameters:
MEM_TIMEOUT, 16, maximum number of MEM_WAIT cycles before the FSM enters ERROR (must be at least 1)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 address of the instruction in ID
id_rs2  in  5  rs2 address of the instruction in ID
ex_rs1  in  5  rs1 address of the instruction in EX
ex_rs2  in  5  rs2 address of the instruction in EX
ex_rd  in  5  rd address of the instruction in EX
ex_reg_write  in  1  EX instruction writes the register file
ex_result_src  in  2  EX result source; 2'b01 means load
ex_pc_src  in  1  taken branch or jump resolved in EX
mem_rd  in  5  rd address of the instruction in MEM
mem_reg_write  in  1  MEM instruction writes the register file
wb_rd  in  5  rd address of the instruction in WB
wb_reg_write  in  1  WB instruction writes the register file
dmem_req  in  1  MEM stage is accessing data memory this cycle
dmem_ready  in  1  data memory completes the access this cycle
stall_if  out  1  hold the PC
stall_id  out  1  hold the IF/ID register
stall_ex  out  1  hold the ID/EX register
stall_mem  out  1  hold the EX/MEM register
flush_id  out  1  load a bubble into IF/ID
flush_ex  out  1  load a bubble into ID/EX
flush_wb  out  1  load a bubble into MEM/WB (reg_write=0)
forward_a  out  2  select for EX operand A: 00 register file, 01 WB result, 10 MEM ALU result
forward_b  out  2  select for EX operand B, same encoding as forward_a
mem_error  out  1  sticky data-memory timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1
flush_count  out  CNT_W  saturating count of branch-flush cycles

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset puts the FSM in RUN, clears wait_cnt, mem_error and both counters. While reset is high, all stall, flush and forward outputs are 0.
- freeze is a combinational signal:
  - In RUN: freeze = dmem_req & !dmem_ready.
  - In MEM_WAIT: freeze = !dmem_ready.
  - In ERROR: freeze = 1.
- While freeze=1: stall_if, stall_id, stall_ex and stall_mem are all 1; flush_wb=1; flush_id=0; flush_ex=0. Load-use and branch hazards are ignored.
- While freeze=0, hazard priority is branch over load-use:
  - Branch (ex_pc_src=1): flush_id=1 and flush_ex=1; all stalls are 0.
  - Load-use (ex_result_src=01, ex_reg_write=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2): stall_if=1, stall_id=1, flush_ex=1.
  - Otherwise all stall and flush outputs are 0.
- Forwarding is computed combinationally every cycle, including during freeze:
  - forward_a = 10 if mem_reg_write=1, mem_rd!=0 and mem_rd==ex_rs1.
  - Otherwise forward_a = 01 if wb_reg_write=1, wb_rd!=0 and wb_rd==ex_rs1.
  - Otherwise forward_a = 00.
  - forward_b uses the same rules with ex_rs2. MEM takes priority over WB.
- FSM transitions:
  - RUN to MEM_WAIT when dmem_req=1 and dmem_ready=0; wait_cnt is cleared to 0.
  - MEM_WAIT to RUN when dmem_ready=1. In that cycle freeze=0 and normal hazards apply.
  - MEM_WAIT to ERROR when dmem_ready=0 and wait_cnt==MEM_TIMEOUT-1. Otherwise wait_cnt increments by 1.
  - ERROR is terminal until reset. mem_error is set to 1 on entry to ERROR.
- Latency:
  - dmem_ready=1 in the same cycle as dmem_req produces no stall.
  - A timeout gives MEM_TIMEOUT+1 frozen cycles before ERROR.
- Counters:
  - stall_cycles increments on the rising edge of each cycle in which stall_if=1; this includes ERROR cycles.
  - flush_count increments on each branch-flush cycle.
  - Both counters saturate at all-ones and do not wrap.
- Asynchronous reset during MEM_WAIT or ERROR returns the FSM to RUN immediately; outputs are 0 in the next cycle after reset is released.

Test Plan:
- Load-use: ex_result_src=01, ex_reg_write=1, ex_rd=5, id_rs2=5 -> stall_if=1, stall_id=1, flush_ex=1 for one cycle; stall_cycles goes 0 to 1.
- Branch beats load-use: the load-use setup above plus ex_pc_src=1 -> flush_id=1, flush_ex=1, stall_if=0; flush_count=1.
- Forward priority: mem_rd=wb_rd=ex_rs1=7, both reg_write=1 -> forward_a=10. mem_rd=0, wb_rd=7 -> forward_a=01. ex_rs2=0 -> forward_b=00.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles then high -> freeze outputs (all stalls=1, flush_wb=1) for 3 cycles, 0 in the ready cycle, FSM back in RUN, stall_cycles=3.
- Timeout with MEM_TIMEOUT=4: dmem_ready held at 0 -> frozen for 5 cycles, then ERROR with mem_error=1 and freeze held. An asynchronous reset pulse mid-cycle clears mem_error and returns the FSM to RUN.
- Saturation with CNT_W=3: hold a load-use stall for 10 cycles -> stall_cycles stops at 7.
